// File: rtl/vga_sync_if.sv
// vga_sync_if: timing outputs of vga_sync_gen to the connector and character generator.
// Rev 1.0
`default_nettype none

interface vga_sync_if;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing with internal pixel-rate divider.
// Rev 1.0
`default_nettype none

module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  wire logic   CLK,
  input  wire logic   RESET,
  vga_sync_if.master  vga
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_DISP   = 10'(H_DISP);
  localparam logic [9:0] Y_DISP   = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_sync_gen: H_TOTAL exceeds 10-bit pix_x range");
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_sync_gen: V_TOTAL exceeds 10-bit pix_y range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_clk_div_check
    $error("vga_sync_gen: CLK_DIV outside 1..16");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             p_tick_reg;
  logic [9:0]       x_cnt;
  logic [9:0]       y_cnt;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             video_reg;
  logic             hsync_reg;
  logic             vsync_reg;
  logic             hs_active;
  logic             vs_active;
  logic             vid_active;

  // Next-state counts feed the decoders so counts and decodes change together.
  always_comb begin
    x_next = x_cnt;
    y_next = y_cnt;
    if (p_tick_reg) begin
      if (x_cnt == X_LAST) begin
        x_next = '0;
        y_next = (y_cnt == Y_LAST) ? '0 : y_cnt + 10'd1;
      end else begin
        x_next = x_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    hs_active  = (x_next >= HS_START) && (x_next <= HS_END);
    vs_active  = (y_next >= VS_START) && (y_next <= VS_END);
    vid_active = (x_next < X_DISP) && (y_next < Y_DISP);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt    <= '0;
      p_tick_reg <= 1'b0;
    end else begin
      div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      p_tick_reg <= (div_cnt == DIV_LAST);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      video_reg <= 1'b0;
      hsync_reg <= ~SYNC_POL;
      vsync_reg <= ~SYNC_POL;
    end else begin
      x_cnt     <= x_next;
      y_cnt     <= y_next;
      video_reg <= vid_active;
      hsync_reg <= hs_active ? SYNC_POL : ~SYNC_POL;
      vsync_reg <= vs_active ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.p_tick     = p_tick_reg;
  assign vga.pix_x      = x_cnt;
  assign vga.pix_y      = y_cnt;
  assign vga.video_on   = video_reg;
  assign vga.hsync      = hsync_reg;
  assign vga.vsync      = vsync_reg;
  assign vga.frame_tick = p_tick_reg && (x_cnt == X_LAST) && (y_cnt == Y_LAST);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three vga_sync_gen configurations checked cycle by cycle against an arithmetic model.
// Rev 1.0
`default_nettype none

module tb_vga_sync_gen;

  // Small geometry so whole frames fit in a short run.
  localparam int SH_D = 10, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_D = 6,  SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int S_HT = SH_D + SH_F + SH_S + SH_B;
  localparam int S_VT = SV_D + SV_F + SV_S + SV_B;
  localparam int PER_B = 3 * S_HT * S_VT;
  localparam int PER_C = 1 * S_HT * S_VT;

  logic CLK;
  logic RESET;
  int   n;
  int   tests;
  int   errors;
  int   hs_low_a;
  bit   phase1;
  int   last_ft_b;
  int   last_ft_c;

  vga_sync_if if_a ();
  vga_sync_if if_b ();
  vga_sync_if if_c ();

  vga_sync_gen dut_a (
    .CLK   (CLK),
    .RESET (RESET),
    .vga   (if_a)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISP(SH_D), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_DISP(SV_D), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b0)
  ) dut_b (
    .CLK   (CLK),
    .RESET (RESET),
    .vga   (if_b)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISP(SH_D), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_DISP(SV_D), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b1)
  ) dut_c (
    .CLK   (CLK),
    .RESET (RESET),
    .vga   (if_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %h expected %h", tag, n, obs, exp);
    end
  endtask

  // Expected outputs after n CLK edges since reset release, from pixel-index arithmetic.
  // Packed as {p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick}.
  function automatic logic [24:0] model(input int cyc, input int d,
                                        input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb,
                                        input bit pol);
    int ht, vt, p, x, y;
    bit pt, vid, hsa, vsa, ft;
    if (cyc == 0) return {1'b0, 10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0};
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    pt  = (cyc % d) == 0;
    p   = (cyc - 1) / d;
    x   = p % ht;
    y   = (p / ht) % vt;
    vid = (x < hd) && (y < vd);
    hsa = (x >= hd + hf) && (x < hd + hf + hs);
    vsa = (y >= vd + vf) && (y < vd + vf + vs);
    ft  = pt && (x == ht - 1) && (y == vt - 1);
    return {pt, 10'(x), 10'(y), vid, hsa ? pol : ~pol, vsa ? pol : ~pol, ft};
  endfunction

  function automatic logic [24:0] pack(input logic pt, input logic [9:0] x, input logic [9:0] y,
                                       input logic vid, input logic hs, input logic vs,
                                       input logic ft);
    return {pt, x, y, vid, hs, vs, ft};
  endfunction

  task automatic compare_all();
    logic [24:0] oa, ob, oc;
    oa = pack(if_a.p_tick, if_a.pix_x, if_a.pix_y, if_a.video_on, if_a.hsync, if_a.vsync, if_a.frame_tick);
    ob = pack(if_b.p_tick, if_b.pix_x, if_b.pix_y, if_b.video_on, if_b.hsync, if_b.vsync, if_b.frame_tick);
    oc = pack(if_c.p_tick, if_c.pix_x, if_c.pix_y, if_c.video_on, if_c.hsync, if_c.vsync, if_c.frame_tick);
    check("dflt_outputs", {7'd0, oa}, {7'd0, model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
    check("div3_outputs", {7'd0, ob}, {7'd0, model(n, 3, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b0)});
    check("div1_outputs", {7'd0, oc}, {7'd0, model(n, 1, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1)});
    if (phase1 && n >= 1 && n <= 3200 && if_a.hsync === 1'b0) hs_low_a++;
    if (if_b.frame_tick === 1'b1) begin
      if (last_ft_b >= 0) check("div3_frame_period", 32'(n - last_ft_b), 32'(PER_B));
      last_ft_b = n;
    end
    if (if_c.frame_tick === 1'b1) begin
      if (last_ft_c >= 0) check("div1_frame_period", 32'(n - last_ft_c), 32'(PER_C));
      last_ft_c = n;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    n = RESET ? 0 : n + 1;
    @(negedge CLK);
    compare_all();
  endtask

  // Asynchronous reset pulse placed between clock edges, checked before the next edge.
  task automatic reset_pulse(input int len);
    #2 RESET = 1'b1;
    n = 0;
    last_ft_b = -1;
    last_ft_c = -1;
    #1 compare_all();
    repeat (len) step();
    RESET = 1'b0;
  endtask

  initial begin
    tests     = 0;
    errors    = 0;
    n         = 0;
    hs_low_a  = 0;
    phase1    = 1'b0;
    last_ft_b = -1;
    last_ft_c = -1;
    RESET     = 1'b1;
    repeat (3) step();
    RESET  = 1'b0;
    phase1 = 1'b1;
    // Two full default lines plus many small frames without interruption.
    repeat (7000) step();
    phase1 = 1'b0;
    check("dflt_hsync_low_clks", 32'(hs_low_a), 32'd384);
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(1, 1400)) step();
      reset_pulse($urandom_range(1, 5));
    end
    repeat (700) step();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
